seq_mult_ctrl: RTL and testbench

Sequential WIDTH×WIDTH unsigned multiplier. It time-multiplexes a single 2-bit×2-bit combinational multiplier cell (inputs A[1:0], B[1:0]; output Y[3:0]) across all digit pairs of the operands. Each shifted partial product is accumulated into a 2·WIDTH-bit register. The block sits in the ALU as the multi-cycle MUL unit, with a start/busy/done handshake toward the ALU control.

---
 rtl/seq_mult_if.sv | 24 ++
 rtl/seq_mult_ctrl.sv | 116 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// Start/busy/done handshake and operand/result bus of the sequential multiplier.
// Contract: the master raises start with a and b valid. The request is taken on
// the first rising edge where the slave is idle (busy=0). When the operation
// finishes, the slave pulses done for one cycle and product is valid.
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2-bit cell.
// The block visits every digit pair (i outer, j inner) once and adds each
// shifted partial product into a 2*WIDTH-bit accumulator. The last step writes
// product and pulses done, so completion takes N*N cycles with N = WIDTH/2.
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mult_if.slave    bus,
    output logic         dbg_state   // 1 while in RUN
);
    localparam int N  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;
    logic            done_r;
    logic [PW-1:0]   product_r;

    logic            last_step;
    logic [1:0]      a_dig;
    logic [1:0]      b_dig;
    logic [3:0]      cell_y;
    logic [CW:0]     digit_sum;
    logic [CW+1:0]   shamt;
    logic [PW-1:0]   acc_next;

    assign last_step = (i == LAST) && (j == LAST);

    // Digit mux, 2x2 cell, shift and add: the partial-product datapath.
    always_comb begin
        a_dig     = 2'(a_r >> {i, 1'b0});
        b_dig     = 2'(b_r >> {j, 1'b0});
        cell_y    = {2'b00, a_dig} * {2'b00, b_dig};
        digit_sum = {1'b0, i} + {1'b0, j};
        shamt     = {digit_sum, 1'b0};
        acc_next  = acc + (PW'(cell_y) << shamt);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start only matters in IDLE; RUN ends on the last digit pair.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; busy follows the registered state only.
    always_comb begin
        bus.busy  = (state == RUN);
        dbg_state = (state == RUN);
    end

    // Operand capture, digit counters, accumulator, result and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                        acc <= '0;
                        i   <= '0;
                        j   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last_step) begin
                        product_r <= acc_next;
                        done_r    <= 1'b1;
                    end else if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: an 8-bit and a 4-bit instance on one clock.
module tb_seq_mult_ctrl;
    logic clk;
    logic rst_n;
    logic dbg8;
    logic dbg4;
    int   errors;
    int   checks;

    seq_mult_if #(.WIDTH(8)) m8 ();
    seq_mult_if #(.WIDTH(4)) m4 ();

    seq_mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave), .dbg_state(dbg8));
    seq_mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(m4.slave), .dbg_state(dbg4));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // One pulsed operation on the 8-bit unit. lat is the number of edges from
    // the accepting edge to the edge that raised done (-1 on timeout).
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] prod, output bit busy_ok);
        m8.start = 1'b1;
        m8.a     = a;
        m8.b     = b;
        cyc();
        m8.start = 1'b0;
        lat      = -1;
        prod     = '0;
        busy_ok  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (m8.done) begin
                lat  = k;
                prod = m8.product;
                break;
            end else if (!m8.busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output logic [7:0] prod);
        m4.start = 1'b1;
        m4.a     = a;
        m4.b     = b;
        cyc();
        m4.start = 1'b0;
        lat      = -1;
        prod     = '0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (m4.done) begin
                lat  = k;
                prod = m4.product;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        m8.start = 1'b0; m8.a = '0; m8.b = '0;
        m4.start = 1'b0; m4.a = '0; m4.b = '0;
        repeat (3) cyc();
        checks++; if (m8.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy8 got=%b exp=0", m8.busy); end
        checks++; if (m8.done !== 1'b0)       begin errors++; $display("FAIL reset_done8 got=%b exp=0", m8.done); end
        checks++; if (m8.product !== 16'h0)   begin errors++; $display("FAIL reset_product8 got=%h exp=0000", m8.product); end
        checks++; if (m4.product !== 8'h0)    begin errors++; $display("FAIL reset_product4 got=%h exp=00", m4.product); end
        rst_n = 1'b1;
        repeat (2) cyc();
        checks++; if (m8.busy !== 1'b0)       begin errors++; $display("FAIL idle_busy8 got=%b exp=0", m8.busy); end
    endtask

    task automatic test_max();
        int lat; logic [15:0] prod; bit busy_ok;
        do_op8(8'hFF, 8'hFF, lat, prod, busy_ok);
        checks++; if (lat !== 16)        begin errors++; $display("FAIL max_latency got=%0d exp=16", lat); end
        checks++; if (prod !== 16'hFE01) begin errors++; $display("FAIL max_product got=%h exp=fe01", prod); end
        checks++; if (busy_ok !== 1'b1)  begin errors++; $display("FAIL max_busy_during_run got=%b exp=1", busy_ok); end
        checks++; if (m8.busy !== 1'b0)  begin errors++; $display("FAIL max_busy_at_done got=%b exp=0", m8.busy); end
        cyc();
        checks++; if (m8.done !== 1'b0)  begin errors++; $display("FAIL max_done_one_cycle got=%b exp=0", m8.done); end
        checks++; if (m8.product !== 16'hFE01) begin errors++; $display("FAIL max_product_hold got=%h exp=fe01", m8.product); end
    endtask

    task automatic test_hold();
        int lat; logic [15:0] prod; bit busy_ok;
        bit held;
        do_op8(8'hA5, 8'h3C, lat, prod, busy_ok);
        checks++; if (prod !== 16'h26AC) begin errors++; $display("FAIL a5x3c_product got=%h exp=26ac", prod); end
        cyc();
        // Zero operand still runs all 16 steps; product holds the old value meanwhile.
        m8.start = 1'b1; m8.a = 8'h00; m8.b = 8'hFF;
        cyc();
        m8.start = 1'b0;
        held = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (m8.done) begin
                lat = k;
                break;
            end
            if (m8.product !== 16'h26AC) held = 1'b0;
        end
        checks++; if (held !== 1'b1)         begin errors++; $display("FAIL zero_product_held got=%b exp=1", held); end
        checks++; if (lat !== 16)            begin errors++; $display("FAIL zero_latency got=%0d exp=16", lat); end
        checks++; if (m8.product !== 16'h0)  begin errors++; $display("FAIL zero_product got=%h exp=0000", m8.product); end
        cyc();
    endtask

    task automatic test_ignore_start();
        int lat; int extra;
        m8.start = 1'b1; m8.a = 8'h12; m8.b = 8'h34;
        cyc();
        m8.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                m8.start = 1'b1; m8.a = 8'h01; m8.b = 8'h01;
            end else if (k == 6) begin
                m8.start = 1'b0;
            end
            cyc();
            if (m8.done) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 16)             begin errors++; $display("FAIL ignore_latency got=%0d exp=16", lat); end
        checks++; if (m8.product !== 16'h03A8) begin errors++; $display("FAIL ignore_product got=%h exp=03a8", m8.product); end
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (m8.done) extra++;
        end
        checks++; if (extra !== 0)            begin errors++; $display("FAIL ignore_no_second_done got=%0d exp=0", extra); end
        checks++; if (m8.busy !== 1'b0)       begin errors++; $display("FAIL ignore_idle_after got=%b exp=0", m8.busy); end
    endtask

    task automatic test_back_to_back();
        int  d[3];
        int  n;
        bit  prev_done;
        bit  reaccept_ok;
        bit  busy_drop_ok;
        bit  prod_ok;
        m8.start = 1'b1; m8.a = 8'h03; m8.b = 8'h05;
        cyc();                       // first accepting edge = edge 0
        n = 0; prev_done = 1'b0; reaccept_ok = 1'b1; busy_drop_ok = 1'b1; prod_ok = 1'b1;
        d[0] = -1; d[1] = -1; d[2] = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            if (prev_done && m8.busy !== 1'b1) reaccept_ok = 1'b0;
            prev_done = 1'b0;
            if (m8.done) begin
                if (m8.busy !== 1'b0) busy_drop_ok = 1'b0;
                if (m8.product !== 16'h000F) prod_ok = 1'b0;
                d[n] = k;
                n++;
                prev_done = 1'b1;
                if (n == 3) begin
                    m8.start = 1'b0;
                    break;
                end
            end
        end
        m8.start = 1'b0;
        // Each result takes 16 RUN edges; the done cycle is the IDLE cycle that re-accepts.
        checks++; if (d[0] !== 16)        begin errors++; $display("FAIL b2b_done0 got=%0d exp=16", d[0]); end
        checks++; if (d[1] !== 33)        begin errors++; $display("FAIL b2b_done1 got=%0d exp=33", d[1]); end
        checks++; if (d[2] !== 50)        begin errors++; $display("FAIL b2b_done2 got=%0d exp=50", d[2]); end
        checks++; if (prod_ok !== 1'b1)   begin errors++; $display("FAIL b2b_product got=%h exp=000f", m8.product); end
        checks++; if (busy_drop_ok !== 1'b1) begin errors++; $display("FAIL b2b_busy_drop got=%b exp=1", busy_drop_ok); end
        checks++; if (reaccept_ok !== 1'b1)  begin errors++; $display("FAIL b2b_reaccept got=%b exp=1", reaccept_ok); end
        cyc();
        checks++; if (m8.busy !== 1'b0)   begin errors++; $display("FAIL b2b_stop got=%b exp=0", m8.busy); end
    endtask

    task automatic test_async_reset();
        int extra;
        m8.start = 1'b1; m8.a = 8'hFF; m8.b = 8'hFF;
        cyc();
        m8.start = 1'b0;
        repeat (7) cyc();
        #2;
        rst_n = 1'b0;               // mid-cycle, no clock edge involved
        #1;
        checks++; if (m8.busy !== 1'b0)     begin errors++; $display("FAIL areset_busy got=%b exp=0", m8.busy); end
        checks++; if (m8.done !== 1'b0)     begin errors++; $display("FAIL areset_done got=%b exp=0", m8.done); end
        checks++; if (m8.product !== 16'h0) begin errors++; $display("FAIL areset_product got=%h exp=0000", m8.product); end
        checks++; if (dbg8 !== 1'b0)        begin errors++; $display("FAIL areset_state got=%b exp=0", dbg8); end
        cyc();
        cyc();
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (m8.done || m8.busy) extra++;
        end
        checks++; if (extra !== 0)          begin errors++; $display("FAIL areset_no_done got=%0d exp=0", extra); end
    endtask

    task automatic test_width4();
        int lat; logic [7:0] prod;
        do_op4(4'hF, 4'hF, lat, prod);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL w4_latency got=%0d exp=4", lat); end
        checks++; if (prod !== 8'hE1)  begin errors++; $display("FAIL w4_ffxff got=%h exp=e1", prod); end
        cyc();
        do_op4(4'hA, 4'h3, lat, prod);
        checks++; if (lat !== 4)       begin errors++; $display("FAIL w4_latency2 got=%0d exp=4", lat); end
        checks++; if (prod !== 8'h1E)  begin errors++; $display("FAIL w4_ax3 got=%h exp=1e", prod); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
